beam_thresh_loader: RTL

Threshold loader driving the threshold side of an array of dual-beam threshold DSPs. It owns a shadow register file with one 18-bit threshold per beam, written through a valid/ready port. On commit it streams every shadow value onto the shared threshold bus, one per-beam clock-enable strobe per cycle, then issues a single common update strobe so all beams switch thresholds together. It sits between the control register space and the beam DSP array.

---
 rtl/beam_thresh_loader_if.sv | 26 ++
 rtl/beam_thresh_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/beam_thresh_loader_if.sv
// beam_thresh_loader_if: shadow write port and shared threshold bus of the loader
interface beam_thresh_loader_if #(
   parameter int NBEAMS = 48,
   parameter int IDXW   = $clog2(NBEAMS)
);
   logic              wr_valid_i;
   logic              wr_ready_o;
   logic [IDXW-1:0]   wr_beam_i;
   logic [17:0]       wr_thresh_i;
   logic              commit_i;
   logic [17:0]       thresh_o;
   logic [NBEAMS-1:0] thresh_ce_o;
   logic              update_o;
   logic              busy_o;
   logic              done_o;

   modport master (
      output wr_valid_i, wr_beam_i, wr_thresh_i, commit_i,
      input  wr_ready_o, thresh_o, thresh_ce_o, update_o, busy_o, done_o
   );

   modport slave (
      input  wr_valid_i, wr_beam_i, wr_thresh_i, commit_i,
      output wr_ready_o, thresh_o, thresh_ce_o, update_o, busy_o, done_o
   );
endinterface

// File: rtl/beam_thresh_loader.sv
// beam_thresh_loader: shadow threshold file streamed to the beam DSPs on commit
module beam_thresh_loader #(
   parameter int          NBEAMS         = 48,
   parameter logic [17:0] DEFAULT_THRESH = 18'h13880,
   parameter int          IDXW           = $clog2(NBEAMS)
) (
   input logic                 clk_i,
   input logic                 rst_i,
   beam_thresh_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d, idx_nxt;
   logic              pending_q, pending_d;
   logic [17:0]       thresh_q, thresh_d, thresh_sel;
   logic [NBEAMS-1:0] ce_q, ce_d;
   logic              update_q, update_d;
   logic              done_q, done_d;
   logic [17:0]       shadow_q [NBEAMS];
   logic [17:0]       shadow_d [NBEAMS];
   logic              busy, wr_fire;

   assign busy    = state_q != IDLE;
   assign wr_fire = bus.wr_valid_i && !busy && !rst_i;

   // Shadow write; indices at or above NBEAMS match no entry and are dropped
   always_comb begin
      for (int i = 0; i < NBEAMS; i++)
         shadow_d[i] = (wr_fire && bus.wr_beam_i == IDXW'(i)) ? bus.wr_thresh_i : shadow_q[i];
   end

   // Next entry to stream; reading shadow_d lets a write on the start edge land in the sequence
   always_comb begin
      idx_nxt    = busy ? idx_q + IDXW'(1) : '0;
      thresh_sel = '0;
      for (int i = 0; i < NBEAMS; i++)
         if (idx_nxt == IDXW'(i)) thresh_sel = shadow_d[i];
   end

   // Sequencer: next state plus registered bus outputs for the coming cycle
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q | (busy & bus.commit_i);
      thresh_d  = thresh_q;
      ce_d      = '0;
      update_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (bus.commit_i || pending_q) begin
            state_d   = LOAD;
            idx_d     = '0;
            pending_d = 1'b0;
            thresh_d  = thresh_sel;
            ce_d      = NBEAMS'(1);
         end
         LOAD: if (idx_q != IDXW'(NBEAMS - 1)) begin
            idx_d    = idx_nxt;
            thresh_d = thresh_sel;
            ce_d     = NBEAMS'(1) << idx_nxt;
         end else begin
            state_d  = UPDATE;
            update_d = 1'b1;
         end
         UPDATE: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset reloads defaults and arms an automatic load
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pending_q <= 1'b1;
         thresh_q  <= '0;
         ce_q      <= '0;
         update_q  <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < NBEAMS; i++) shadow_q[i] <= DEFAULT_THRESH;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         thresh_q  <= thresh_d;
         ce_q      <= ce_d;
         update_q  <= update_d;
         done_q    <= done_d;
         for (int i = 0; i < NBEAMS; i++) shadow_q[i] <= shadow_d[i];
      end
   end

   assign bus.thresh_o    = thresh_q;
   assign bus.thresh_ce_o = ce_q;
   assign bus.update_o    = update_q;
   assign bus.done_o      = done_q;
   assign bus.busy_o      = busy;
   assign bus.wr_ready_o  = !busy && !rst_i;
endmodule
